// File: rtl/alu_pkg.sv
// Shared types and constants for the iterative HI/LO divider.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [ALU_WIDTH-1:0] INT_MIN = 32'h8000_0000;
  localparam logic [ALU_WIDTH-1:0] DZ_QUOT = 32'hFFFF_FFFF;
  localparam logic [ALU_WIDTH-1:0] NEG_ONE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ADJ  = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // One extra bit keeps the compare exact for unsigned divisors near 2^WIDTH.
  assign shifted  = {rem, dvd_msb};
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = (shifted >= {1'b0, divisor});
  assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/alu_div.sv
// Multi-cycle restoring divider for DIV/DIVU; quotient to LO (Q), remainder to HI (R).
module alu_div
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             Sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DZ,
  output logic             V
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] dvd_reg, rem_reg, quo_reg, dsr_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             sign_reg, sq_reg, sr_reg;
  logic             busy_reg, done_reg, dz_reg, v_reg;
  logic [WIDTH-1:0] q_reg, r_reg;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic             b_zero;
  logic             dz_hold;

  function automatic logic [WIDTH-1:0] mag(input logic s, input logic [WIDTH-1:0] x);
    return (s & x[WIDTH-1]) ? -x : x;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .dvd_msb  (dvd_reg[WIDTH-1]),
    .divisor  (dsr_reg),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign b_zero  = (b_reg == '0);
  // Divide-by-zero spends two edges in ADJ so its done lands at T0+2.
  assign dz_hold = b_zero && (cnt_reg == '0);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = (B == '0) ? ADJ : CALC;
      CALC: if (cnt_reg == CNT_W'(WIDTH - 1)) state_next = ADJ;
      ADJ:  if (!dz_hold) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      dvd_reg   <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      dsr_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sign_reg  <= 1'b0;
      sq_reg    <= 1'b0;
      sr_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      dz_reg    <= 1'b0;
      v_reg     <= 1'b0;
      q_reg     <= '0;
      r_reg     <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg    <= A;
            b_reg    <= B;
            sign_reg <= Sign;
            sq_reg   <= Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
            sr_reg   <= Sign & A[WIDTH-1];
            dvd_reg  <= mag(Sign, A);
            dsr_reg  <= mag(Sign, B);
            rem_reg  <= '0;
            quo_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b1;
          end
        end
        CALC: begin
          rem_reg <= rem_next;
          dvd_reg <= dvd_reg << 1;
          quo_reg <= {quo_reg[WIDTH-2:0], q_bit};
          cnt_reg <= cnt_reg + 1'b1;
        end
        ADJ: begin
          if (dz_hold) begin
            cnt_reg <= cnt_reg + 1'b1;
          end else begin
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
            if (b_zero) begin
              q_reg  <= WIDTH'(DZ_QUOT);
              r_reg  <= a_reg;
              dz_reg <= 1'b1;
              v_reg  <= 1'b0;
            end else begin
              // Negating zero yields zero, so sign fix-up never makes a zero result nonzero.
              q_reg  <= sq_reg ? -quo_reg : quo_reg;
              r_reg  <= sr_reg ? -rem_reg : rem_reg;
              dz_reg <= 1'b0;
              v_reg  <= sign_reg & (a_reg == WIDTH'(INT_MIN)) & (b_reg == WIDTH'(NEG_ONE));
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign Q    = q_reg;
  assign R    = r_reg;
  assign DZ   = dz_reg;
  assign V    = v_reg;

endmodule

// File: tb/tb_alu_div.sv
// Directed self-checking bench for alu_div: latency, signs, overflow, divide-by-zero, back-to-back, abort.
module tb_alu_div;

  logic        clk;
  logic        reset;
  logic        start;
  logic        Sign;
  logic [31:0] A, B;
  logic        busy, done, DZ, V;
  logic [31:0] Q, R;

  int          n_asserts = 0;
  int          n_fail    = 0;
  logic [31:0] q_at_t0, r_at_t0;

  alu_div dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .Sign  (Sign),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
    .R     (R),
    .DZ    (DZ),
    .V     (V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    A     = a;
    B     = b;
    Sign  = s;
    start = 1'b1;
  endtask

  // Waits from the accepting edge T0 to done; optionally pulses a second start while busy.
  task automatic wait_done(input string tag, input logic [31:0] eq, input logic [31:0] er,
                           input logic edz, input logic ev, input int elat, input bit inj);
    int lat    = 0;
    int busy_n = 0;
    bit seen   = 0;
    @(posedge clk); #1;
    start   = 1'b0;
    q_at_t0 = Q;
    r_at_t0 = R;
    if (busy) busy_n++;
    while (!seen && lat < 40) begin
      if (inj && lat == 1) begin
        start = 1'b1;
        A     = 32'h0000_1234;
        B     = 32'h0000_0001;
      end
      @(posedge clk); #1;
      lat++;
      if (inj && lat == 2) start = 1'b0;
      if (done) seen = 1;
      else if (busy) busy_n++;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(elat));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_Q"}, Q, eq);
    chk({tag, "_R"}, R, er);
    chk({tag, "_DZ"}, 32'(DZ), 32'(edz));
    chk({tag, "_V"}, 32'(V), 32'(ev));
    $display("txn %s: A=%h B=%h Sign=%0d -> Q=%h R=%h DZ=%0d V=%0d lat=%0d",
             tag, A, B, Sign, Q, R, DZ, V, lat);
  endtask

  task automatic idle_check(input string tag, input int n);
    int k = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (done) k++;
    end
    chk({tag, "_no_extra_done"}, 32'(k), 32'd0);
  endtask

  initial begin
    int pulses;
    reset = 1'b0;
    start = 1'b0;
    Sign  = 1'b0;
    A     = '0;
    B     = '0;
    #12;
    chk("rst_Q", Q, 32'h0);
    chk("rst_R", R, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_DZ", 32'(DZ), 32'd0);
    chk("rst_V", 32'(V), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    launch(32'd100, 32'd7, 1'b0);
    wait_done("u100_7", 32'd14, 32'd2, 1'b0, 1'b0, 33, 1);
    idle_check("u100_7", 5);

    @(negedge clk);
    launch(32'hFFFF_FFF9, 32'h2, 1'b1);
    wait_done("s_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 33, 0);

    @(negedge clk);
    launch(32'hFFFF_FFF9, 32'h2, 1'b0);
    wait_done("u_m7_2", 32'h7FFF_FFFC, 32'h1, 1'b0, 1'b0, 33, 0);

    @(negedge clk);
    launch(32'h7, 32'hFFFF_FFFE, 1'b1);
    wait_done("s_7_m2", 32'hFFFF_FFFD, 32'h1, 1'b0, 1'b0, 33, 0);

    @(negedge clk);
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done("s_ovf", 32'h8000_0000, 32'h0, 1'b0, 1'b1, 33, 0);

    @(negedge clk);
    launch(32'h8000_0000, 32'h2, 1'b1);
    wait_done("s_min_2", 32'hC000_0000, 32'h0, 1'b0, 1'b0, 33, 0);

    @(negedge clk);
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    wait_done("u_big", 32'h1, 32'h1, 1'b0, 1'b0, 33, 0);

    @(negedge clk);
    launch(32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    wait_done("u_big2", 32'h1, 32'h7FFF_FFFE, 1'b0, 1'b0, 33, 0);

    @(negedge clk);
    launch(32'd5, 32'd0, 1'b0);
    wait_done("u_dz", 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, 2, 1);
    idle_check("u_dz", 5);

    @(negedge clk);
    launch(32'd5, 32'd0, 1'b1);
    wait_done("s_dz", 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, 2, 1);
    idle_check("s_dz", 5);

    // Back-to-back: next request raised in the done cycle itself.
    @(negedge clk);
    launch(32'd100, 32'd7, 1'b0);
    wait_done("b2b_first", 32'd14, 32'd2, 1'b0, 1'b0, 33, 0);
    launch(32'd9, 32'd3, 1'b0);
    wait_done("b2b_second", 32'd3, 32'd0, 1'b0, 1'b0, 33, 0);
    chk("b2b_Q_held_at_T0", q_at_t0, 32'd14);
    chk("b2b_R_held_at_T0", r_at_t0, 32'd2);

    // Asynchronous abort during CALC.
    @(negedge clk);
    launch(32'd1000, 32'd3, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("abort_Q", Q, 32'h0);
    chk("abort_R", R, 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_DZ", 32'(DZ), 32'd0);
    chk("abort_V", 32'(V), 32'd0);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) pulses++;
    end
    reset = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    $display("txn abort: reset during CALC, done pulses=%0d", pulses);

    launch(32'd1, 32'd1, 1'b0);
    wait_done("post_rst_1_1", 32'd1, 32'd0, 1'b0, 1'b0, 33, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
